servo_pwm_bank: RTL and testbench
=================================

Name: servo_pwm_bank

Overview:
- Consumes the servo address/position stream produced by the AVR SPI interface (servo_num, servo_pos, new_pos).
- Stores one 8-bit position per channel and drives NUM_SERVOS hobby-servo PWM outputs.
- Each channel produces one pulse per frame; pulse width is linear in its position.
- Position updates are double-buffered so that a pulse never changes width mid-frame.

Parameters:
- NUM_SERVOS, 16, number of output channels, legal range 1..64.
- FRAME_CLKS, 1000000, frame period in clocks (20 ms at 50 MHz).
- MIN_CLKS, 50000, pulse width in clocks for position 0 (1 ms).
- STEP_CLKS, 195, clocks added per position LSB; MIN_CLKS+256*STEP_CLKS must be <= FRAME_CLKS.
- INIT_POS, 128, reset value of all pending and active positions.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- servo_num  in  6  target channel of the update.
- servo_pos  in  8  new position for servo_num.
- new_pos  in  1  single-cycle strobe; servo_num and servo_pos are valid in this cycle.
- servo_out  out  NUM_SERVOS  PWM outputs, one bit per channel.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.
- bad_addr  out  1  one-cycle pulse when an update is rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - servo_out=0, frame_start=0, bad_addr=0.
  - frame_cnt=0, step_cnt=0, state=BASE.
  - All pending and active positions = INIT_POS.
- Update path:
  - On a clk edge with new_pos=1 and servo_num<NUM_SERVOS: pending[servo_num]<=servo_pos.
  - On a clk edge with new_pos=1 and servo_num>=NUM_SERVOS: no write; bad_addr=1 for the following cycle.
  - Later updates to the same channel within a frame overwrite earlier ones; the last one wins.
- Frame counter:
  - frame_cnt runs 0..FRAME_CLKS-1 and wraps.
  - In the cycle with frame_cnt==0: active<=pending (all channels); frame_start=1 from the next edge for exactly 1 cycle.
  - If new_pos arrives in the frame_cnt==0 cycle, active takes the old pending value (no bypass). The new value applies in the next frame.
- State machine (registered outputs, all changing on the same edge):
  - BASE: entered at frame start. All servo_out=1 for MIN_CLKS cycles, then go to STEPS with step_cnt=0.
  - STEPS: step_cnt 0..255; each value lasts STEP_CLKS cycles. servo_out[i]=(step_cnt<active[i]). After step 255 completes, go to REST.
  - REST: all servo_out=0 until frame_cnt wraps; then go to BASE.
- Pulse timing:
  - The rising edge of servo_out[i] coincides with frame_start rising.
  - High time is exactly MIN_CLKS+active[i]*STEP_CLKS consecutive clocks, once per frame.
  - pos=0 gives MIN_CLKS; pos=255 gives MIN_CLKS+255*STEP_CLKS.
- Widths:
  - frame_cnt width = clog2(FRAME_CLKS).
  - Prescaler width = clog2(max(MIN_CLKS,STEP_CLKS)).
  - The comparator per channel is 8-bit unsigned; no multipliers.
- Reset mid-frame: outputs drop immediately. After release, the first clk edge starts a new frame with INIT_POS everywhere.

Test Plan:
Bench parameters: FRAME_CLKS=2000, MIN_CLKS=100, STEP_CLKS=4, NUM_SERVOS=4.
- Release reset, no updates -> every channel pulses 612 clocks high every 2000 clocks. frame_start is aligned with each rising edge.
- Write ch1=0 and ch2=255 mid-frame -> the current frame is unchanged (612). The next frame gives ch1=100 and ch2=1120; ch0 and ch3 stay at 612.
- Write ch3=10 then ch3=20 within one frame -> the next frame's ch3 width is 180; no 140-clock pulse ever appears.
- Write servo_num=5 with pos=7 -> bad_addr high for 1 cycle; all widths unchanged.
- Write ch0=50 exactly in the frame_cnt==0 cycle -> that frame's ch0 width is still the old value; the following frame's width is 300.
- Assert rst_n low mid-pulse -> servo_out=0 asynchronously. After release, all channels give 612 from the first edge, and the previously written positions are discarded.

Source files
------------

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: double-buffered bank of hobby-servo PWM channels fed by an address/position stream
module servo_pwm_bank #(
  parameter int NUM_SERVOS = 16,
  parameter int FRAME_CLKS = 1000000,
  parameter int MIN_CLKS   = 50000,
  parameter int STEP_CLKS  = 195,
  parameter int INIT_POS   = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            servo_num,
  input  logic [7:0]            servo_pos,
  input  logic                  new_pos,
  output logic [NUM_SERVOS-1:0] servo_out,
  output logic                  frame_start,
  output logic                  bad_addr
);
  localparam int FW   = FRAME_CLKS > 1 ? $clog2(FRAME_CLKS) : 1;
  localparam int PMAX = MIN_CLKS > STEP_CLKS ? MIN_CLKS : STEP_CLKS;
  localparam int PW   = PMAX > 1 ? $clog2(PMAX) : 1;
  typedef enum logic [1:0] {BASE, STEPS, REST} state_t;
  state_t                  state, state_nxt;
  logic [FW-1:0]           frame_cnt;
  logic [PW-1:0]           pre, pre_nxt;
  logic [7:0]              step_cnt, step_nxt;
  logic [NUM_SERVOS-1:0]   out_nxt;
  logic [7:0]              pending [NUM_SERVOS];
  logic [7:0]              active  [NUM_SERVOS];
  logic                    addr_ok;
  logic                    frame_zero;
  assign addr_ok    = {1'b0, servo_num} < 7'(NUM_SERVOS);
  assign frame_zero = frame_cnt == '0;
  // next state, prescaler, step and per-channel output level; outputs follow the next state
  always_comb begin
    state_nxt = state;
    pre_nxt   = pre + 1'b1;
    step_nxt  = step_cnt;
    if (frame_zero) begin
      state_nxt = BASE;
      pre_nxt   = '0;
    end else if (state == BASE && pre == PW'(MIN_CLKS - 1)) begin
      state_nxt = STEPS;
      pre_nxt   = '0;
      step_nxt  = '0;
    end else if (state == STEPS && pre == PW'(STEP_CLKS - 1)) begin
      pre_nxt = '0;
      if (step_cnt == 8'd255) state_nxt = REST;
      else step_nxt = step_cnt + 1'b1;
    end
    for (int i = 0; i < NUM_SERVOS; i++)
      out_nxt[i] = state_nxt == BASE || (state_nxt == STEPS && step_nxt < active[i]);
  end
  // frame timing, FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      state       <= BASE;
      pre         <= '0;
      step_cnt    <= '0;
      servo_out   <= '0;
      frame_start <= 1'b0;
      bad_addr    <= 1'b0;
    end else begin
      frame_cnt   <= frame_cnt == FW'(FRAME_CLKS - 1) ? '0 : frame_cnt + 1'b1;
      state       <= state_nxt;
      pre         <= pre_nxt;
      step_cnt    <= step_nxt;
      servo_out   <= out_nxt;
      frame_start <= frame_zero;
      bad_addr    <= new_pos && !addr_ok;
    end
  end
  // pending positions take updates anytime; active copies them only at frame start (old value wins on a collision)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SERVOS; i++) begin
        pending[i] <= 8'(INIT_POS);
        active[i]  <= 8'(INIT_POS);
      end
    end else begin
      if (frame_zero)
        for (int i = 0; i < NUM_SERVOS; i++) active[i] <= pending[i];
      if (new_pos && addr_ok) pending[servo_num[$clog2(NUM_SERVOS > 1 ? NUM_SERVOS : 2)-1:0]] <= servo_pos;
    end
  end
endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb_servo_pwm_bank: randomized scoreboard bench for servo_pwm_bank
module tb_servo_pwm_bank;
  localparam int N = 4, FRAME = 2000, MIN = 100, STEP = 4;
  logic clk, rst_n, new_pos;
  logic [5:0] servo_num;
  logic [7:0] servo_pos;
  logic [N-1:0] servo_out;
  logic frame_start, bad_addr;
  int checks = 0, errors = 0, cyc = 0, fc = 0;
  int mpend [N];
  int mact [N];
  int exp_w [N][$];
  int fs_q [$];
  int bad_q [$];
  int run [N];
  bit prev [N];
  int e_m;

  servo_pwm_bank #(.NUM_SERVOS(N), .FRAME_CLKS(FRAME), .MIN_CLKS(MIN), .STEP_CLKS(STEP), .INIT_POS(128)) dut (
    .clk(clk), .rst_n(rst_n), .servo_num(servo_num), .servo_pos(servo_pos), .new_pos(new_pos),
    .servo_out(servo_out), .frame_start(frame_start), .bad_addr(bad_addr));

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string nm, input int got, input int want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mpend[i] = 128;
      mact[i] = 128;
      exp_w[i].delete();
    end
    fs_q.delete();
    bad_q.delete();
    fc = 0;
  endtask

  // one clock of the reference: frame start latches pending and predicts every pulse width
  task automatic model_edge(input bit nv, input int num, input int pos);
    if (fc == 0) begin
      for (int i = 0; i < N; i++) begin
        mact[i] = mpend[i];
        exp_w[i].push_back(MIN + mact[i] * STEP);
      end
      fs_q.push_back(cyc + 1);
    end
    if (nv) begin
      if (num < N) mpend[num] = pos;
      else bad_q.push_back(cyc + 1);
    end
    fc = (fc + 1) % FRAME;
  endtask

  task automatic tick(input bit nv, input int num, input int pos);
    @(negedge clk);
    new_pos = nv;
    servo_num = 6'(num);
    servo_pos = 8'(pos);
    model_edge(nv, num, pos);
  endtask

  task automatic run_to(input int f);
    while (fc != f) tick(0, 0, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1;
  endtask

  // monitor: measures each high run and pops the expected width on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        run[i] = 0;
        prev[i] = 0;
      end
    end else begin
      if (frame_start) begin
        if (fs_q.size() == 0) chk(0, "frame_start_unexpected", cyc, -1);
        else begin
          e_m = fs_q.pop_front();
          chk(e_m == cyc, "frame_start_cycle", cyc, e_m);
        end
      end
      if (bad_addr) begin
        if (bad_q.size() == 0) chk(0, "bad_addr_unexpected", cyc, -1);
        else begin
          e_m = bad_q.pop_front();
          chk(e_m == cyc, "bad_addr_cycle", cyc, e_m);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (servo_out[i]) begin
          if (!prev[i]) chk(frame_start == 1'b1, $sformatf("rise_align_ch%0d", i), int'(frame_start), 1);
          run[i]++;
        end else if (prev[i]) begin
          if (exp_w[i].size() == 0) chk(0, $sformatf("width_unexpected_ch%0d", i), run[i], -1);
          else begin
            e_m = exp_w[i].pop_front();
            chk(run[i] == e_m, $sformatf("width_ch%0d", i), run[i], e_m);
          end
          run[i] = 0;
        end
        prev[i] = servo_out[i];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    new_pos = 0;
    servo_num = 0;
    servo_pos = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk(servo_out == '0, "reset_servo_out", int'(servo_out), 0);
    chk(frame_start == 0, "reset_frame_start", int'(frame_start), 0);
    chk(bad_addr == 0, "reset_bad_addr", int'(bad_addr), 0);
    release_reset();
    run_to(500);
    tick(1, 1, 0);
    tick(1, 2, 255);
    run_to(700);
    tick(1, 3, 10);
    run_to(900);
    tick(1, 3, 20);
    run_to(1200);
    tick(1, 5, 7);
    run_to(0);
    run_to(0);
    tick(1, 0, 50);
    run_to(0);
    run_to(0);
    repeat (3 * FRAME) begin
      if ($urandom_range(49) == 0) tick(1, $urandom_range(7), $urandom_range(255));
      else tick(0, 0, 0);
    end
    run_to(0);
    tick(1, 0, 3);
    tick(1, 1, 200);
    run_to(0);
    run_to(300);
    #2 rst_n = 0;
    #1;
    chk(servo_out == '0, "async_reset_servo_out", int'(servo_out), 0);
    chk(frame_start == 0, "async_reset_frame_start", int'(frame_start), 0);
    model_reset();
    repeat (2) @(posedge clk);
    release_reset();
    run_to(0);
    run_to(0);
    run_to(1500);
    for (int i = 0; i < N; i++)
      chk(exp_w[i].size() == 0, $sformatf("pulses_missing_ch%0d", i), exp_w[i].size(), 0);
    chk(fs_q.size() == 0, "frame_start_missing", fs_q.size(), 0);
    chk(bad_q.size() == 0, "bad_addr_missing", bad_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
